// File: rtl/factor_engine_pkg.sv
// Shared types and constants for the trial-division factorizer.
// Imported by the interface, the divider and the top FSM.
package factorize_pkg;

    localparam int WIDTH         = 8;
    localparam int FIRST_DIVISOR = 2;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        DIV,
        EMIT
    } state_t;

endpackage

// File: rtl/factor_engine_if.sv
// Valid/ready stream carrying prime factors to the display sequencer.
// The engine drives it as master; the consumer is the slave.
interface factor_engine_if
    import factorize_pkg::*;
#(
    parameter int WIDTH = factorize_pkg::WIDTH
);

    logic             factor_valid;
    logic             factor_ready;
    logic [WIDTH-1:0] factor;
    logic             factor_last;

    modport master (
        output factor_valid,
        output factor,
        output factor_last,
        input  factor_ready
    );

    modport slave (
        input  factor_valid,
        input  factor,
        input  factor_last,
        output factor_ready
    );

endinterface

// File: rtl/factor_engine_divider.sv
// Repeated-subtraction divider: one subtraction per cycle after load,
// div_done rises once the accumulator drops below the divisor.
module sub_divider
    import factorize_pkg::*;
#(
    parameter int WIDTH = factorize_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_done
);

    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_q;
    logic             w_done;

    assign w_done = (r_acc < divisor);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc <= '0;
            r_q   <= '0;
        end else if (load) begin
            r_acc <= dividend;
            r_q   <= '0;
        end else if (!w_done) begin
            r_acc <= r_acc - divisor;
            r_q   <= r_q + WIDTH'(1);
        end
    end

    assign quotient  = r_q;
    assign remainder = r_acc;
    assign div_done  = w_done;

endmodule

// File: rtl/factor_engine.sv
// Trial-division prime factorizer: captures a number on start and streams
// its prime factors in ascending order (with repeats) over valid/ready.
module factor_engine
    import factorize_pkg::*;
#(
    parameter int WIDTH = factorize_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] number,
    output logic             busy,
    output logic             done,
    factor_engine_if.master  fac
);

    state_t           r_state;
    state_t           w_state_nx;
    logic [WIDTH-1:0] r_n;
    logic [WIDTH-1:0] w_n_nx;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] w_d_nx;
    logic [WIDTH-1:0] r_factor;
    logic [WIDTH-1:0] w_factor_nx;
    logic             r_last;
    logic             w_last_nx;
    logic             r_valid;
    logic             w_valid_nx;
    logic             r_done;
    logic             w_done_nx;
    logic             w_load;

    logic [2*WIDTH-1:0] w_d_ext;
    logic [2*WIDTH-1:0] w_n_ext;
    logic [2*WIDTH-1:0] w_dd;

    logic [WIDTH-1:0] w_quot;
    logic [WIDTH-1:0] w_rem;
    logic             w_div_done;

    // Square at double width so d*d never wraps for any WIDTH-bit d.
    assign w_d_ext = {{WIDTH{1'b0}}, r_d};
    assign w_n_ext = {{WIDTH{1'b0}}, r_n};
    assign w_dd    = w_d_ext * w_d_ext;

    sub_divider #(
        .WIDTH (WIDTH)
    ) u_div (
        .clk       (clk),
        .reset     (reset),
        .load      (w_load),
        .dividend  (r_n),
        .divisor   (r_d),
        .quotient  (w_quot),
        .remainder (w_rem),
        .div_done  (w_div_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_n      <= '0;
            r_d      <= WIDTH'(FIRST_DIVISOR);
            r_factor <= '0;
            r_last   <= 1'b0;
            r_valid  <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_n      <= w_n_nx;
            r_d      <= w_d_nx;
            r_factor <= w_factor_nx;
            r_last   <= w_last_nx;
            r_valid  <= w_valid_nx;
            r_done   <= w_done_nx;
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_n_nx      = r_n;
        w_d_nx      = r_d;
        w_factor_nx = r_factor;
        w_last_nx   = r_last;
        w_valid_nx  = r_valid;
        w_done_nx   = 1'b0;
        w_load      = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_n_nx     = number;
                    w_d_nx     = WIDTH'(FIRST_DIVISOR);
                    w_state_nx = CHECK;
                end
            end
            CHECK: begin
                // 0 and 1 are emitted as-is; otherwise n is prime once d*d > n.
                if (r_n <= WIDTH'(1) || w_dd > w_n_ext) begin
                    w_factor_nx = r_n;
                    w_last_nx   = 1'b1;
                    w_valid_nx  = 1'b1;
                    w_state_nx  = EMIT;
                end else begin
                    w_load     = 1'b1;
                    w_state_nx = DIV;
                end
            end
            DIV: begin
                if (w_div_done) begin
                    if (w_rem == '0) begin
                        w_factor_nx = r_d;
                        w_last_nx   = 1'b0;
                        w_valid_nx  = 1'b1;
                        w_n_nx      = w_quot;
                        w_state_nx  = EMIT;
                    end else begin
                        w_d_nx     = r_d + WIDTH'(1);
                        w_state_nx = CHECK;
                    end
                end
            end
            EMIT: begin
                if (fac.factor_ready) begin
                    w_valid_nx = 1'b0;
                    if (r_last) begin
                        w_done_nx  = 1'b1;
                        w_state_nx = IDLE;
                    end else begin
                        w_state_nx = CHECK;
                    end
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    assign busy             = (r_state != IDLE);
    assign done             = r_done;
    assign fac.factor_valid = r_valid;
    assign fac.factor       = r_factor;
    assign fac.factor_last  = r_last;

endmodule
